// File: rtl/alu_result_stage.sv
// Execute-to-writeback boundary: registers ALU results into a small skid FIFO toward
// writeback and turns taken branches/jumps into a one-cycle front-end redirect.
module alu_result_stage #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter int REG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_result,
  input  logic             in_branch_ctrl,
  input  logic [3:0]       in_op,
  input  logic             in_jal,
  input  logic [WIDTH-1:0] in_pc,
  input  logic [WIDTH-1:0] in_imm,
  input  logic             in_jalr,
  input  logic [REG_W-1:0] in_rd,
  input  logic             in_rd_we,
  input  logic             flush,
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic [WIDTH-1:0] wb_data,
  output logic [REG_W-1:0] wb_rd,
  output logic             redirect_valid,
  output logic [WIDTH-1:0] redirect_pc
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic {RUN, SHADOW} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic               in_ready_q, in_ready_d;
  logic               redirect_valid_q, redirect_valid_d;
  logic [WIDTH-1:0]   redirect_pc_q, redirect_pc_d;

  logic [WIDTH-1:0]   mem_data_q [DEPTH];
  logic [REG_W-1:0]   mem_rd_q   [DEPTH];

  logic               accept, is_branch, taken, push, pop;
  logic [WIDTH-1:0]   target, wdata;

  // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
  always_comb begin
    accept    = in_valid & in_ready_q & (state_q == RUN) & ~flush;
    is_branch = (in_op >= 4'd9) && (in_op <= 4'd12);
    taken     = in_jal | (is_branch & in_branch_ctrl);
    push      = accept & in_rd_we & (in_rd != '0);
    pop       = (count_q != '0) & wb_ready;
    target    = in_jalr ? {in_result[WIDTH-1:1], 1'b0} : in_pc + in_imm;
    wdata     = in_jal ? in_pc + WIDTH'(4) : in_result;

    state_d          = state_q;
    count_d          = count_q;
    wr_ptr_d         = wr_ptr_q;
    rd_ptr_d         = rd_ptr_q;
    redirect_valid_d = 1'b0;
    redirect_pc_d    = redirect_pc_q;

    if (flush) begin
      // Flush dominates: queue emptied, any new input already excluded from accept.
      state_d  = RUN;
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      state_d  = (accept && taken) ? SHADOW : RUN;
      count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
      wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      if (accept && taken) begin
        redirect_valid_d = 1'b1;
        redirect_pc_d    = target;
      end
    end

    in_ready_d = (state_d == RUN) && (count_d < CNT_W'(DEPTH));
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= RUN;
      count_q          <= '0;
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      in_ready_q       <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
    end else begin
      state_q          <= state_d;
      count_q          <= count_d;
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      in_ready_q       <= in_ready_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
    end
  end

  // NOTE: storage is not reset; entries are only observed while counted valid, and wb_* is
  // forced to zero when empty so the reset-visible outputs stay clean.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data_q[wr_ptr_q] <= wdata;
      mem_rd_q[wr_ptr_q]   <= in_rd;
    end
  end

  assign in_ready       = in_ready_q;
  assign wb_valid       = (count_q != '0);
  assign wb_data        = wb_valid ? mem_data_q[rd_ptr_q] : '0;
  assign wb_rd          = wb_valid ? mem_rd_q[rd_ptr_q]   : '0;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;

endmodule
